// File: rtl/vx_sfu_rsp_sched.sv
// SFU response scheduler: round-robin arbitration of sub-unit commits into a
// 2-entry output queue feeding the gather stage, with per-input grant and
// output-stall perf counters.
module vx_sfu_rsp_sched #(
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned DATAW      = 64,
  parameter int unsigned PERF_W     = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_INPUTS-1:0]          valid_in,
  output logic [NUM_INPUTS-1:0]          ready_in,
  input  logic [NUM_INPUTS*DATAW-1:0]    data_in,
  output logic                           valid_out,
  input  logic                           ready_out,
  output logic [DATAW-1:0]               data_out,
  output logic [$clog2(NUM_INPUTS)-1:0]  sel_out,
  output logic [NUM_INPUTS*PERF_W-1:0]   perf_grants,
  output logic [PERF_W-1:0]              perf_stalls
);

  localparam int unsigned SEL_W = $clog2(NUM_INPUTS);
  localparam int unsigned ENT_W = DATAW + SEL_W;

  logic [1:0]                   count_q, count_d;
  logic [SEL_W-1:0]             ptr_q, ptr_d;
  logic [ENT_W-1:0]             head_q, head_d;
  logic [ENT_W-1:0]             tail_q, tail_d;
  logic [NUM_INPUTS*PERF_W-1:0] grants_q, grants_d;
  logic [PERF_W-1:0]            stalls_q, stalls_d;

  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] cand;
  logic [DATAW-1:0] grant_data;
  logic             can_push;
  logic             push;
  logic             pop;

  // Queue head and perf counters are presented straight from the flops.
  assign valid_out   = (count_q != 2'd0);
  assign data_out    = head_q[ENT_W-1:SEL_W];
  assign sel_out     = head_q[SEL_W-1:0];
  assign perf_grants = grants_q;
  assign perf_stalls = stalls_q;

  assign can_push = (count_q != 2'd2);
  assign pop      = valid_out & ready_out;

  // Round-robin pick: first valid input after the last winner; the descending
  // scan lets the nearest candidate overwrite farther ones.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = int'(NUM_INPUTS); k >= 1; k--) begin
      cand = SEL_W'((int'(ptr_q) + k) % int'(NUM_INPUTS));
      if (valid_in[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Accept strobe and selected payload; nothing is accepted while in reset.
  always_comb begin
    ready_in   = '0;
    push       = reset & can_push & grant_vld;
    grant_data = '0;
    if (push) begin
      ready_in[grant_idx] = 1'b1;
    end
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data = data_in[i*DATAW +: DATAW];
      end
    end
  end

  // Next state: pop shifts tail to head, push lands in the first free slot.
  always_comb begin
    count_d  = count_q;
    ptr_d    = ptr_q;
    head_d   = head_q;
    tail_d   = tail_q;
    grants_d = grants_q;
    stalls_d = stalls_q;
    if (pop) begin
      head_d  = tail_q;
      count_d = count_q - 2'd1;
    end
    if (push) begin
      ptr_d = grant_idx;
      if (count_d == 2'd0) begin
        head_d = {grant_data, grant_idx};
      end else begin
        tail_d = {grant_data, grant_idx};
      end
      count_d = count_d + 2'd1;
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
        if (grant_idx == SEL_W'(i)) begin
          grants_d[i*PERF_W +: PERF_W] = grants_q[i*PERF_W +: PERF_W] + PERF_W'(1);
        end
      end
    end
    if (valid_out && !ready_out) begin
      stalls_d = stalls_q + PERF_W'(1);
    end
  end

  // State registers; reset empties the queue and points rr so input 0 wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q  <= 2'd0;
      ptr_q    <= SEL_W'(NUM_INPUTS - 1);
      head_q   <= '0;
      tail_q   <= '0;
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      count_q  <= count_d;
      ptr_q    <= ptr_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      grants_q <= grants_d;
      stalls_q <= stalls_d;
    end
  end

endmodule

// File: tb/tb_vx_sfu_rsp_sched.sv
// Bench for vx_sfu_rsp_sched: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_vx_sfu_rsp_sched;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 64;
  localparam int unsigned PW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     valid_in;
  logic [1:0]     ready_in;
  logic [127:0]   data_in;
  logic           valid_out;
  logic           ready_out;
  logic [63:0]    data_out;
  logic [0:0]     sel_out;
  logic [7:0]     perf_grants;
  logic [3:0]     perf_stalls;

  int total = 0;
  int bad   = 0;

  vx_sfu_rsp_sched #(.NUM_INPUTS(N), .DATAW(DW), .PERF_W(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .ready_in    (ready_in),
    .data_in     (data_in),
    .valid_out   (valid_out),
    .ready_out   (ready_out),
    .data_out    (data_out),
    .sel_out     (sel_out),
    .perf_grants (perf_grants),
    .perf_stalls (perf_stalls)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: FIFO of granted responses ----------------
  typedef struct {
    logic [63:0] d;
    int          s;
  } ent_t;

  ent_t mq[$];
  int   m_last = 1;
  int   m_g[2] = '{0, 0};
  int   m_st   = 0;

  function automatic logic [1:0] m_ready(input logic rst, input logic [1:0] v);
    logic [1:0] r;
    r = 2'b00;
    if (rst && mq.size() < 2) begin
      for (int k = 1; k <= 2; k++) begin
        if (v[(m_last + k) % 2]) begin
          r[(m_last + k) % 2] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic m_step(input logic rst, input logic [1:0] v, input logic ro,
                        input logic [63:0] d0, input logic [63:0] d1);
    logic [1:0] r;
    logic       vo;
    ent_t       e;
    if (!rst) begin
      mq.delete();
      m_last = 1;
      m_g    = '{0, 0};
      m_st   = 0;
    end else begin
      r  = m_ready(rst, v);
      vo = (mq.size() != 0);
      if (vo && !ro) m_st = (m_st + 1) % 16;
      if (vo && ro) void'(mq.pop_front());
      for (int i = 0; i < 2; i++) begin
        if (r[i]) begin
          e.d = (i == 1) ? d1 : d0;
          e.s = i;
          mq.push_back(e);
          m_last = i;
          m_g[i] = (m_g[i] + 1) % 16;
        end
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Apply inputs just after a rising edge and settle to the falling edge.
  task automatic drive(input logic rst, input logic [1:0] v, input logic ro,
                       input logic [63:0] d0, input logic [63:0] d1);
    reset     = rst;
    valid_in  = v;
    ready_out = ro;
    data_in   = {d1, d0};
    @(negedge clk);
  endtask

  // Advance the model with the applied inputs, then cross the next rising edge.
  task automatic tick();
    m_step(reset, valid_in, ready_out, data_in[63:0], data_in[127:64]);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    chk("rnd_ready_in", 64'(ready_in), 64'(m_ready(reset, valid_in)));
    chk("rnd_valid_out", 64'(valid_out), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("rnd_data_out", data_out, mq[0].d);
      chk("rnd_sel_out", 64'(sel_out), 64'(mq[0].s));
    end
    chk("rnd_grants0", 64'(perf_grants[3:0]), 64'(m_g[0]));
    chk("rnd_grants1", 64'(perf_grants[7:4]), 64'(m_g[1]));
    chk("rnd_stalls", 64'(perf_stalls), 64'(m_st));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic        ro;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [1:0]  ri;
    logic        vo;
    logic        chk_d;
    logic        sel;
    logic [63:0] dout;
    logic [3:0]  g0;
    logic [3:0]  g1;
    logic [3:0]  st;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [1:0] v, input logic ro,
                              input logic [63:0] d0, input logic [63:0] d1,
                              input logic [1:0] ri, input logic vo, input logic chk_d,
                              input logic sel, input logic [63:0] dout,
                              input logic [3:0] g0, input logic [3:0] g1, input logic [3:0] st);
    vec_t t;
    t.rst = rst; t.v = v; t.ro = ro; t.d0 = d0; t.d1 = d1;
    t.ri = ri; t.vo = vo; t.chk_d = chk_d; t.sel = sel; t.dout = dout;
    t.g0 = g0; t.g1 = g1; t.st = st;
    return t;
  endfunction

  vec_t tbl[18];

  logic [1:0]  pv;
  logic [63:0] pd[2];
  logic [1:0]  r;
  logic        rst_r;
  logic        ro_r;
  int          thr;

  initial begin
    // rst v ro d0 d1 | ri vo chk_d sel dout g0 g1 st
    tbl[0]  = mk(0, 2'b00, 1, 0,     0,     2'b00, 0, 1, 0, 0,     0, 0, 0);
    tbl[1]  = mk(1, 2'b11, 1, 'h11,  'h22,  2'b01, 0, 1, 0, 0,     0, 0, 0);
    tbl[2]  = mk(1, 2'b11, 1, 'h11,  'h22,  2'b10, 1, 1, 0, 'h11,  1, 0, 0);
    tbl[3]  = mk(1, 2'b11, 1, 'h11,  'h22,  2'b01, 1, 1, 1, 'h22,  1, 1, 0);
    tbl[4]  = mk(1, 2'b10, 1, 'h11,  'h22,  2'b10, 1, 1, 0, 'h11,  2, 1, 0);
    tbl[5]  = mk(1, 2'b10, 1, 'h11,  'hA5,  2'b10, 1, 1, 1, 'h22,  2, 2, 0);
    tbl[6]  = mk(1, 2'b10, 1, 'h11,  'hA5,  2'b10, 1, 1, 1, 'hA5,  2, 3, 0);
    tbl[7]  = mk(1, 2'b10, 1, 'h11,  'hA5,  2'b10, 1, 1, 1, 'hA5,  2, 4, 0);
    tbl[8]  = mk(0, 2'b00, 1, 0,     0,     2'b00, 1, 1, 1, 'hA5,  2, 5, 0);
    tbl[9]  = mk(0, 2'b00, 1, 0,     0,     2'b00, 0, 1, 0, 0,     0, 0, 0);
    tbl[10] = mk(1, 2'b11, 0, 'h33,  'h44,  2'b01, 0, 1, 0, 0,     0, 0, 0);
    tbl[11] = mk(1, 2'b11, 0, 'h33,  'h44,  2'b10, 1, 1, 0, 'h33,  1, 0, 0);
    tbl[12] = mk(1, 2'b01, 0, 'h55,  'h44,  2'b00, 1, 1, 0, 'h33,  1, 1, 1);
    tbl[13] = mk(1, 2'b01, 0, 'h55,  'h44,  2'b00, 1, 1, 0, 'h33,  1, 1, 2);
    tbl[14] = mk(1, 2'b01, 1, 'h55,  'h44,  2'b00, 1, 1, 0, 'h33,  1, 1, 3);
    tbl[15] = mk(1, 2'b01, 1, 'h55,  'h44,  2'b01, 1, 1, 1, 'h44,  1, 1, 3);
    tbl[16] = mk(1, 2'b00, 1, 'h55,  'h44,  2'b00, 1, 1, 0, 'h55,  2, 1, 3);
    tbl[17] = mk(1, 2'b00, 1, 0,     0,     2'b00, 0, 0, 0, 0,     2, 1, 3);

    reset = 1'b0; valid_in = 2'b00; ready_out = 1'b0; data_in = '0;
    drive(0, 2'b00, 0, 0, 0); tick();
    drive(0, 2'b00, 0, 0, 0); tick();

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].ro, tbl[i].d0, tbl[i].d1);
      chk($sformatf("tbl%0d_ready_in", i), 64'(ready_in), 64'(tbl[i].ri));
      chk($sformatf("tbl%0d_valid_out", i), 64'(valid_out), 64'(tbl[i].vo));
      if (tbl[i].chk_d) begin
        chk($sformatf("tbl%0d_data_out", i), data_out, tbl[i].dout);
        chk($sformatf("tbl%0d_sel_out", i), 64'(sel_out), 64'(tbl[i].sel));
      end
      chk($sformatf("tbl%0d_grants0", i), 64'(perf_grants[3:0]), 64'(tbl[i].g0));
      chk($sformatf("tbl%0d_grants1", i), 64'(perf_grants[7:4]), 64'(tbl[i].g1));
      chk($sformatf("tbl%0d_stalls", i), 64'(perf_stalls), 64'(tbl[i].st));
      tick();
    end

    // 17 pushes from input 0 wrap its 4-bit grant counter to 1.
    drive(0, 2'b00, 1, 0, 0); tick();
    for (int i = 0; i < 17; i++) begin
      drive(1, 2'b01, 1, 64'(i + 100), 0); tick();
    end
    drive(1, 2'b00, 1, 0, 0);
    chk("wrap_grants0", 64'(perf_grants[3:0]), 64'd1);
    chk("wrap_grants1", 64'(perf_grants[7:4]), 64'd0);
    chk("wrap_last_data", data_out, 64'd116);
    tick();

    // Reset with a full queue: drops entries, rr restarts at input 0.
    drive(0, 2'b00, 1, 0, 0); tick();
    drive(1, 2'b01, 0, 'hC0, 'hC1); tick();
    drive(1, 2'b01, 0, 'hC2, 'hC1); tick();
    drive(1, 2'b00, 0, 0, 'hC1);
    chk("full_ready_in", 64'(ready_in), 64'd0);
    chk("full_valid_out", 64'(valid_out), 64'd1);
    tick();
    drive(0, 2'b00, 0, 0, 0); tick();
    drive(1, 2'b11, 0, 'hD0, 'hD1);
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_first_grant", 64'(ready_in), 64'b01);
    chk("rst_grants", 64'(perf_grants), 64'd0);
    chk("rst_stalls", 64'(perf_stalls), 64'd0);
    tick();

    // Randomized run; requesters hold valid/data until accepted.
    drive(0, 2'b00, 1, 0, 0); tick();
    pv = 2'b00;
    pd[0] = '0;
    pd[1] = '0;
    thr = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 256 == 0) begin
        case ($urandom_range(0, 2))
          0:       thr = 15;
          1:       thr = 60;
          default: thr = 100;
        endcase
      end
      rst_r = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i] = 1'b1;
          pd[i] = {$urandom, $urandom};
        end
      end
      ro_r = ($urandom_range(1, 100) <= thr);
      drive(rst_r, pv, ro_r, pd[0], pd[1]);
      check_model();
      r = m_ready(rst_r, pv);
      for (int i = 0; i < 2; i++) begin
        if (r[i]) pv[i] = 1'b0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
